riscv_dmem_access_sequencer: RTL and testbench

- Parametrised successor to the single-cycle data-memory request decoder.
- Accepts one load/store request at a time and generates aligned bus beats. A misaligned access that crosses a bus-word boundary becomes two sequential beats.
- Merges read lanes from both beats, then rotates and sign- or zero-extends the result.
- Sits between the execute stage and the data-memory bus, and replaces combinational misalignment handling with a handshaked sequencer.

---
 rtl/riscv_dmem_access_sequencer.sv | 112 +++++++++++
 tb/tb_riscv_dmem_access_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_access_sequencer.sv
// riscv_dmem_access_sequencer: splits load/store requests into aligned bus beats and forms extended load results
module riscv_dmem_access_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter bit ALLOW_MISALIGNED = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_address,
  input  logic [1:0]              req_width,
  input  logic                    req_write,
  input  logic                    req_unsigned,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    mem_valid,
  input  logic                    mem_ack,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic                    mem_write_enable,
  output logic                    mem_read_enable,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_fault,
  output logic                    resp_split
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS = $clog2(BYTES);
  localparam logic [1:0] IDLE = 2'd0, BEAT1 = 2'd1, BEAT2 = 2'd2, FAULT = 2'd3;
  logic [1:0] state, width_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [OFS-1:0] offset, off_q;
  logic [OFS+2:0] wsh, rsh;
  logic [4:0] size;
  logic [2*BYTES-1:0] mask, be_wide;
  logic [BYTES-1:0] be1_q, be2_q;
  logic [DATA_WIDTH-1:0] wrot, wdata_q, hold_q, lanes, merged, rrot, ext;
  logic write_q, unsigned_q, split_q, misaligned, split, illegal, fault, last_ack, sign;
  assign offset = req_address[OFS-1:0];
  assign size = 5'd1 << req_width;
  assign mask = ~({2*BYTES{1'b1}} << size);
  // lanes past the bus word spill into the upper half and become the second beat
  assign be_wide = mask << offset;
  assign misaligned = (5'(offset) & (size - 5'd1)) != 5'd0;
  assign split = 5'(offset) + size > 5'(BYTES);
  assign illegal = size > 5'(BYTES);
  assign fault = illegal | (misaligned & !ALLOW_MISALIGNED);
  assign wsh = {offset, 3'b000};
  assign wrot = (req_wdata << wsh) | (req_wdata >> (DATA_WIDTH - int'(wsh)));
  assign req_ready = state == IDLE;
  assign mem_valid = state == BEAT1 || state == BEAT2;
  assign mem_read_enable = mem_valid & !write_q;
  assign mem_write_enable = mem_valid & write_q;
  assign mem_address = state == BEAT2 ? addr_q + ADDR_WIDTH'(BYTES) : addr_q;
  assign mem_byte_enable = state == BEAT2 ? be2_q : be1_q;
  assign mem_write_data = wdata_q;
  assign last_ack = mem_ack & ((state == BEAT1 & !split_q) | state == BEAT2);
  assign rsh = {off_q, 3'b000};
  always_comb begin
    lanes = '0;
    for (int i = 0; i < BYTES; i++) lanes[i*8 +: 8] = {8{mem_byte_enable[i]}};
    merged = (state == BEAT2 ? hold_q : '0) | (mem_read_data & lanes);
    rrot = (merged >> rsh) | (merged << (DATA_WIDTH - int'(rsh)));
    sign = !unsigned_q & (width_q == 2'd0 ? rrot[7] : width_q == 2'd1 ? rrot[15] : rrot[31]);
    ext = '0;
    for (int i = 0; i < DATA_WIDTH; i++) ext[i] = i < (8 << width_q) ? rrot[i] : sign;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_split <= 1'b0;
      resp_data <= '0;
      hold_q <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        state <= fault ? FAULT : BEAT1;
        addr_q <= {req_address[ADDR_WIDTH-1:OFS], OFS'(0)};
        off_q <= offset;
        width_q <= req_width;
        write_q <= req_write;
        unsigned_q <= req_unsigned;
        split_q <= split;
        be1_q <= be_wide[BYTES-1:0];
        be2_q <= be_wide[2*BYTES-1:BYTES];
        wdata_q <= wrot;
      end
      if (state == FAULT) begin
        state <= IDLE;
        resp_valid <= 1'b1;
        resp_fault <= 1'b1;
        resp_split <= 1'b0;
        resp_data <= '0;
      end
      if (state == BEAT1 && mem_ack) begin
        hold_q <= merged;
        state <= BEAT2;
      end
      if (last_ack) begin
        state <= IDLE;
        resp_valid <= 1'b1;
        resp_fault <= 1'b0;
        resp_split <= split_q;
        resp_data <= write_q ? '0 : ext;
      end
    end
  end
endmodule

// File: tb/tb_riscv_dmem_access_sequencer.sv
// tb_riscv_dmem_access_sequencer: directed checks of beat generation, lane merging, faults and reset abort
module tb_riscv_dmem_access_sequencer;
  logic clk = 0, reset_n = 0;
  logic req_valid = 0, n_req_valid = 0, req_write = 0, req_unsigned = 0, mem_ack = 0;
  logic [31:0] req_address = 0, req_wdata = 0, mem_read_data = 0;
  logic [1:0] req_width = 0;
  logic req_ready, mem_valid, mem_write_enable, mem_read_enable, resp_valid, resp_fault, resp_split;
  logic [31:0] mem_address, mem_write_data, resp_data;
  logic [3:0] mem_byte_enable;
  logic n_req_ready, n_mem_valid, n_mem_we, n_mem_re, n_resp_valid, n_resp_fault, n_resp_split;
  logic [31:0] n_mem_address, n_mem_wdata, n_resp_data;
  logic [3:0] n_mem_be;
  int checks = 0, failures = 0, n_mv_seen = 0, resp_seen = 0;

  always #5 clk = ~clk;

  riscv_dmem_access_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_width(req_width), .req_write(req_write),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .mem_valid(mem_valid),
    .mem_ack(mem_ack), .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .resp_split(resp_split)
  );

  riscv_dmem_access_sequencer #(.ALLOW_MISALIGNED(0)) u_nomis (
    .clk(clk), .reset_n(reset_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_address(req_address), .req_width(req_width), .req_write(req_write),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .mem_valid(n_mem_valid),
    .mem_ack(mem_ack), .mem_address(n_mem_address), .mem_byte_enable(n_mem_be),
    .mem_write_enable(n_mem_we), .mem_read_enable(n_mem_re),
    .mem_write_data(n_mem_wdata), .mem_read_data(mem_read_data),
    .resp_valid(n_resp_valid), .resp_data(n_resp_data), .resp_fault(n_resp_fault),
    .resp_split(n_resp_split)
  );

  always @(posedge clk) if (n_mem_valid) n_mv_seen <= n_mv_seen + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] w, input logic wr, input logic u, input logic [31:0] wd);
    req_address = a; req_width = w; req_write = wr; req_unsigned = u; req_wdata = wd;
    req_valid = 1;
    step();
    req_valid = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    reset_n = 1;
    step();
    // word load 0x100
    issue(32'h100, 2'd2, 0, 0, 0);
    chk("wl_mem_valid", mem_valid, 1);
    chk("wl_addr", mem_address, 32'h100);
    chk("wl_be", mem_byte_enable, 4'hF);
    chk("wl_re", mem_read_enable, 1);
    chk("wl_we", mem_write_enable, 0);
    chk("wl_resp_early", resp_valid, 0);
    mem_ack = 1; mem_read_data = 32'hDEADBEEF;
    step();
    mem_ack = 0;
    chk("wl_resp_valid", resp_valid, 1);
    chk("wl_resp_data", resp_data, 32'hDEADBEEF);
    chk("wl_split", resp_split, 0);
    chk("wl_fault", resp_fault, 0);
    chk("wl_ready_in_resp", req_ready, 1);
    chk("wl_mem_idle", mem_valid, 0);
    // signed byte load 0x103
    issue(32'h103, 2'd0, 0, 0, 0);
    chk("sb_be", mem_byte_enable, 4'h8);
    chk("sb_addr", mem_address, 32'h100);
    mem_ack = 1; mem_read_data = 32'h80123456;
    step();
    mem_ack = 0;
    chk("sb_resp_valid", resp_valid, 1);
    chk("sb_resp_data", resp_data, 32'hFFFFFF80);
    // misaligned word store 0x102
    issue(32'h102, 2'd2, 1, 0, 32'h11223344);
    chk("st_b1_addr", mem_address, 32'h100);
    chk("st_b1_be", mem_byte_enable, 4'hC);
    chk("st_b1_wdata", mem_write_data, 32'h33441122);
    chk("st_b1_we", mem_write_enable, 1);
    chk("st_b1_re", mem_read_enable, 0);
    mem_ack = 1;
    step();
    chk("st_b2_valid", mem_valid, 1);
    chk("st_b2_addr", mem_address, 32'h104);
    chk("st_b2_be", mem_byte_enable, 4'h3);
    chk("st_b2_wdata", mem_write_data, 32'h33441122);
    chk("st_b2_no_resp", resp_valid, 0);
    step();
    mem_ack = 0;
    chk("st_resp_valid", resp_valid, 1);
    chk("st_resp_split", resp_split, 1);
    chk("st_resp_data", resp_data, 0);
    // unsigned half load 0x103 with wait states in beat 2
    issue(32'h103, 2'd1, 0, 1, 0);
    chk("uh_b1_be", mem_byte_enable, 4'h8);
    mem_ack = 1; mem_read_data = 32'hAB000000;
    step();
    mem_ack = 0; mem_read_data = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      chk("uh_wait_addr", mem_address, 32'h104);
      chk("uh_wait_be", mem_byte_enable, 4'h1);
      chk("uh_wait_valid", mem_valid, 1);
      step();
    end
    chk("uh_no_resp", resp_valid, 0);
    mem_ack = 1; mem_read_data = 32'h000000CD;
    step();
    mem_ack = 0;
    chk("uh_resp_valid", resp_valid, 1);
    chk("uh_resp_data", resp_data, 32'h0000CDAB);
    chk("uh_resp_split", resp_split, 1);
    // misaligned word load without misalignment support
    req_address = 32'h101; req_width = 2'd2; req_write = 0; req_unsigned = 0;
    n_req_valid = 1;
    step();
    n_req_valid = 0;
    chk("nm_no_mem_valid", n_mem_valid, 0);
    chk("nm_ready_low", n_req_ready, 0);
    step();
    chk("nm_resp_valid", n_resp_valid, 1);
    chk("nm_resp_fault", n_resp_fault, 1);
    chk("nm_resp_data", n_resp_data, 0);
    chk("nm_ready", n_req_ready, 1);
    step();
    chk("nm_never_mem_valid", n_mv_seen, 0);
    // illegal dword width on a 32-bit bus
    issue(32'h100, 2'd3, 0, 0, 0);
    chk("dw_no_mem_valid", mem_valid, 0);
    step();
    chk("dw_resp_valid", resp_valid, 1);
    chk("dw_resp_fault", resp_fault, 1);
    step();
    chk("dw_pulse_end", resp_valid, 0);
    // reset while waiting in beat 2
    issue(32'h102, 2'd2, 0, 0, 0);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("ab_in_b2", mem_valid, 1);
    chk("ab_b2_addr", mem_address, 32'h104);
    reset_n = 0;
    step();
    chk("ab_mem_valid", mem_valid, 0);
    chk("ab_ready", req_ready, 1);
    chk("ab_resp_valid", resp_valid, 0);
    reset_n = 1; mem_ack = 1;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) resp_seen++;
      step();
    end
    mem_ack = 0;
    chk("ab_no_resp_after", resp_seen, 0);
    chk("ab_still_idle", mem_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
